// File: rtl/cpu_mc_pkg.sv
// Shared encodings, ALU op and FSM state types for the cpu_mc core.
// Instret counter is built only when CPU_MC_INSTRET_EN is defined.
package cpu_mc_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        TRAP
    } state_e;

    function automatic logic [31:0] aluCalc(
        input alu_op_e     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        r = a + b;
        unique case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: two async read ports, one sync write port, x0 hardwired 0.
// Asynchronous active-high reset clears every register.
module cpu_mc_regfile #(
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rAddr1,
    input  logic [AW-1:0] rAddr2,
    output logic [31:0]   rData1,
    output logic [31:0]   rData2,
    input  logic          we,
    input  logic [AW-1:0] wAddr,
    input  logic [31:0]   wData
);

    logic [31:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wAddr != '0) begin
            regs[wAddr] <= wData;
        end
    end

    assign rData1 = (rAddr1 == '0) ? '0 : regs[rAddr1];
    assign rData2 = (rAddr2 == '0) ? '0 : regs[rAddr2];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32 subset core: FETCH -> EXEC -> (MEM) -> FETCH, sticky TRAP.
// Optional retired-instruction counter: define CPU_MC_INSTRET_EN.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          NREG      = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        trap,
    output logic [31:0] instret
);

    localparam int AW = $clog2(NREG);

    state_e      state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] ir, irNext;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] immI, immS, immB, immJ;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    assign immI = {{20{ir[31]}}, ir[31:20]};
    assign immS = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign immJ = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic [31:0] rs1Val, rs2Val, rfWdata;
    logic        rfWe;

    cpu_mc_regfile #(.NREG(NREG)) uRegs (
        .clk    (clk),
        .reset  (reset),
        .rAddr1 (rs1[AW-1:0]),
        .rAddr2 (rs2[AW-1:0]),
        .rData1 (rs1Val),
        .rData2 (rs2Val),
        .we     (rfWe),
        .wAddr  (rd[AW-1:0]),
        .wData  (rfWdata)
    );

    alu_op_e aluOp;
    logic    isAlu, isImm, isLoad, isStore, isBeq, isJal, isJalr, illegal;

    always_comb begin
        aluOp   = ALU_ADD;
        isAlu   = 1'b0;
        isImm   = 1'b0;
        isLoad  = 1'b0;
        isStore = 1'b0;
        isBeq   = 1'b0;
        isJal   = 1'b0;
        isJalr  = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            opcode == OP_REG && f7 == F7_BASE && f3 == F3_ADD: isAlu = 1'b1;
            opcode == OP_REG && f7 == F7_SUB && f3 == F3_ADD: begin
                isAlu = 1'b1;
                aluOp = ALU_SUB;
            end
            opcode == OP_REG && f7 == F7_BASE && f3 == F3_AND: begin
                isAlu = 1'b1;
                aluOp = ALU_AND;
            end
            opcode == OP_REG && f7 == F7_BASE && f3 == F3_OR: begin
                isAlu = 1'b1;
                aluOp = ALU_OR;
            end
            opcode == OP_REG && f7 == F7_BASE && f3 == F3_SLT: begin
                isAlu = 1'b1;
                aluOp = ALU_SLT;
            end
            opcode == OP_IMM && f3 == F3_ADD: begin
                isAlu = 1'b1;
                isImm = 1'b1;
            end
            opcode == OP_LOAD && f3 == F3_LW:     isLoad  = 1'b1;
            opcode == OP_STORE && f3 == F3_SW:    isStore = 1'b1;
            opcode == OP_BRANCH && f3 == F3_BEQ:  isBeq   = 1'b1;
            opcode == OP_JAL:                     isJal   = 1'b1;
            opcode == OP_JALR && f3 == F3_JALR:   isJalr  = 1'b1;
            default:                              illegal = 1'b1;
        endcase
    end

    // Only fields the format actually uses count against a 16-entry file
    logic useRd, useRs1, useRs2, regBad, bad;

    assign useRd  = isAlu | isLoad | isJal | isJalr;
    assign useRs1 = ~isJal & ~illegal;
    assign useRs2 = (isAlu & ~isImm) | isStore | isBeq;
    assign regBad = (NREG == 16) &&
                    ((useRd && rd[4]) || (useRs1 && rs1[4]) || (useRs2 && rs2[4]));
    assign bad    = illegal | regBad;

    logic [31:0] aluRes, memAddr, target, link;
    logic        taken, misalign;

    assign aluRes   = aluCalc(aluOp, rs1Val, isImm ? immI : rs2Val);
    assign memAddr  = rs1Val + (isStore ? immS : immI);
    assign link     = pc + 32'd4;
    assign taken    = isJal | isJalr | (isBeq && rs1Val == rs2Val);
    assign target   = isJalr ? ((rs1Val + immI) & ~32'h1)
                             : pc + (isJal ? immJ : immB);
    assign misalign = taken && target[1:0] != 2'b00;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        irNext    = ir;
        rfWe      = 1'b0;
        rfWdata   = aluRes;
        unique case (state)
            FETCH: begin
                if (imem_ack) begin
                    irNext    = imem_rdata;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                if (bad || misalign) begin
                    stateNext = TRAP;
                end else if (isLoad || isStore) begin
                    stateNext = MEM;
                end else begin
                    rfWe      = useRd;
                    rfWdata   = (isJal || isJalr) ? link : aluRes;
                    pcNext    = taken ? target : link;
                    stateNext = FETCH;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    rfWe      = isLoad;
                    rfWdata   = dmem_rdata;
                    pcNext    = link;
                    stateNext = FETCH;
                end
            end
            TRAP: ;
            default: stateNext = TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_VEC;
            ir    <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            ir    <= irNext;
        end
    end

    // State is already FETCH during reset; the gate keeps the request low
    assign imem_req   = (state == FETCH) && !reset;
    assign imem_addr  = pc;
    assign dmem_req   = (state == MEM);
    assign dmem_we    = (state == MEM) && isStore;
    assign dmem_addr  = (state == MEM) ? memAddr : '0;
    assign dmem_wdata = (state == MEM && isStore) ? rs2Val : '0;
    assign trap       = (state == TRAP);

`ifdef CPU_MC_INSTRET_EN
    logic        retire;
    logic [31:0] instretQ;

    assign retire = (state == EXEC && !bad && !misalign && !isLoad && !isStore) ||
                    (state == MEM && dmem_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instretQ <= '0;
        end else if (retire) begin
            instretQ <= instretQ + 32'd1;
        end
    end

    assign instret = instretQ;
`else
    assign instret = '0;
`endif

endmodule
